seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 91 +++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, overlap/non-overlap
// modes and a saturating match counter.
module seq_detect_param #(
    parameter int unsigned     N       = 4,
    parameter logic [N-1:0]    PATTERN = N'(4'b1101),
    parameter int unsigned     CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             clr_cnt,
    output logic             res,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FILL_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(N - 1);

    logic [N-1:0]      pat_q,  pat_d;
    logic [N-1:0]      hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              res_q,  res_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    logic [N-1:0]      win_c;
    logic              hit_c;

    // Candidate window including the incoming bit, and the qualified hit.
    always_comb begin
        win_c = {hist_q[N-2:0], data};
        hit_c = in_valid && !pat_load && (win_c == pat_q) && (fill_q >= FILL_ARM);
    end

    // Next-state: pattern load wins over sampling; clear wins over increment.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        res_d  = 1'b0;
        cnt_d  = cnt_q;

        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            res_d = hit_c;
            if (hit_c && !overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = win_c;
                fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
            end
            if (hit_c && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            res_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            res_q  <= res_d;
            cnt_q  <= cnt_d;
        end
    end

    assign res       = res_q;
    assign match_cnt = cnt_q;

endmodule
